// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - Datapath widths and program depth
//   - Opcode and FSM state encodings
//   - Packed program-entry type {op, b}
package alu_op_sequencer_pkg;

    localparam int B_W        = 4;
    localparam int ACC_W      = 8;
    localparam int PC_W       = 3;
    localparam int PROG_DEPTH = 1 << PC_W;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_LOGIC = 3'd1,
        OP_ANY   = 3'd2,
        OP_ALL   = 3'd3,
        OP_SHL   = 3'd4,
        OP_MUL   = 3'd5,
        OP_CLR   = 3'd6,
        OP_HALT  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        op_e            op;
        logic [B_W-1:0] b;
    } instr_t;

    // The last program slot: executing a non-HALT here ends the run.
    function automatic logic is_last_pc(input logic [PC_W-1:0] pc);
        return &pc;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_step_core.sv
// alu_step_core: purely combinational single ALU step.
// Ports:
//   op       in  3      opcode (op_e encoding)
//   acc      in  ACC_W  current accumulator
//   b        in  B_W    operand
//   acc_next out ACC_W  accumulator after the operation (truncated)
//   carry    out 1      carry-out of the accumulator MSB, only meaningful for ADD
module alu_step_core
    import alu_op_sequencer_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ACC_W-1:0] acc,
    input  logic [B_W-1:0]   b,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0]   sum;
    logic [B_W-1:0]   acc_lo;

    assign acc_lo = acc[B_W-1:0];
    assign sum    = {1'b0, acc} + {{(ACC_W+1-B_W){1'b0}}, b};

    always_comb begin
        acc_next = acc;
        carry    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                acc_next = sum[ACC_W-1:0];
                carry    = sum[ACC_W];
            end
            OP_LOGIC: acc_next = {acc_lo ^ b, acc_lo | b};
            OP_ANY:   acc_next = (|b) ? 8'h81 : 8'h00;
            OP_ALL:   acc_next = (&b) ? 8'h7E : 8'h00;
            OP_SHL: begin
                // Shift amount is the low accumulator nibble; anything that
                // would push every bit out is forced to zero explicitly.
                if (acc_lo >= 4'd8) begin
                    acc_next = '0;
                end else begin
                    acc_next = {{(ACC_W-B_W){1'b0}}, b} << acc_lo;
                end
            end
            OP_MUL:   acc_next = {{(ACC_W-B_W){1'b0}}, acc_lo} * {{(ACC_W-B_W){1'b0}}, b};
            OP_CLR:   acc_next = '0;
            OP_HALT:  acc_next = acc;
            default:  acc_next = acc;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs an up-to-8-entry program of ALU operations
// against an 8-bit accumulator, free-running or single-stepped.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   prog_we/addr/op/b   program write port (ignored while running)
//   start               strobe: begin a run from pc=0 (ignored while running)
//   step_mode, step     1 = execute only on step strobe; 0 = one instr/cycle
//   busy, done          RUN / DONE state indicators
//   acc, pc, op_cur     accumulator, next instruction index, opcode at pc
//   overflow            sticky ADD carry-out, cleared on start
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [PC_W-1:0]  prog_addr,
    input  logic [2:0]       prog_op,
    input  logic [B_W-1:0]   prog_b,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       op_cur,
    output logic             overflow
);

    state_e           state_reg, state_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;

    instr_t           prog_reg [PROG_DEPTH];
    logic [PROG_DEPTH-1:0] entry_we;
    logic             wr_ok;
    instr_t           cur_instr;

    logic [ACC_W-1:0] alu_acc;
    logic             alu_carry;
    logic             execute;

    // ------------------------------------------------------------------
    // Program store. Kept in flops rather than RAM because every entry
    // must return to HALT on reset.
    // ------------------------------------------------------------------
    assign wr_ok = prog_we && (state_reg != ST_RUN);

    generate
        for (genvar gi = 0; gi < PROG_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = wr_ok && (prog_addr == PC_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < PROG_DEPTH; i++) begin
            if (reset) begin
                prog_reg[i].op <= OP_HALT;
                prog_reg[i].b  <= '0;
            end else if (entry_we[i]) begin
                prog_reg[i].op <= op_e'(prog_op);
                prog_reg[i].b  <= prog_b;
            end
        end
    end

    assign cur_instr = prog_reg[pc_reg];

    alu_step_core u_core (
        .op       (cur_instr.op),
        .acc      (acc_reg),
        .b        (cur_instr.b),
        .acc_next (alu_acc),
        .carry    (alu_carry)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        execute    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // DONE keeps the final acc/overflow visible until restarted.
                if (start) begin
                    state_next = ST_RUN;
                    pc_next    = '0;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            ST_RUN: begin
                execute = step_mode ? step : 1'b1;
                if (execute) begin
                    if (cur_instr.op == OP_HALT) begin
                        state_next = ST_DONE;
                    end else begin
                        acc_next = alu_acc;
                        if (cur_instr.op == OP_ADD) begin
                            ovf_next = ovf_reg | alu_carry;
                        end
                        if (is_last_pc(pc_reg)) begin
                            pc_next    = '0;
                            state_next = ST_DONE;
                        end else begin
                            pc_next = pc_reg + PC_W'(1);
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy     = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);
    assign acc      = acc_reg;
    assign pc       = pc_reg;
    assign op_cur   = cur_instr.op;
    assign overflow = ovf_reg;

endmodule
